// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared constants and FSM encoding for the change dispenser
package vending_pkg;

  localparam int W           = 12;
  localparam int STOCK_W     = 4;
  localparam int ACK_TIMEOUT = 255;
  localparam int TMO_W       = $clog2(ACK_TIMEOUT + 1);

  localparam logic [W-1:0]       DOLLAR     = W'(100);
  localparam logic [W-1:0]       QUARTER    = W'(25);
  localparam logic [STOCK_W-1:0] STOCK_FULL = '1;
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WAIT_ACK,
    WAIT_REL,
    FINISH
  } state_e;

endpackage

// File: rtl/coin_stock.sv
// rtl/coin_stock.sv - saturating stock counter for one coin denomination
module coin_stock
  import vending_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic dec_i,
  input  logic load_i,
  output logic empty_o
);

  logic [STOCK_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = STOCK_FULL;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= STOCK_FULL;
    end else begin
      count_q <= count_d;
    end
  end

  assign empty_o = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays captured credit back as dollars then quarters via a hopper handshake
module change_dispenser
  import vending_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         refund,
  input  logic [W-1:0] money_in,
  input  logic         load_dollar,
  input  logic         load_quarter,
  input  logic         coin_ack,
  output logic         credit_clr,
  output logic         coin_req,
  output logic         coin_sel,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] residual,
  output logic         short_change,
  output logic         fault,
  output logic         dollar_empty,
  output logic         quarter_empty
);

  state_e           state_q, state_d;
  logic             refund_prev_q;
  logic [W-1:0]     remaining_q, remaining_d;
  logic [W-1:0]     residual_q, residual_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic             coin_req_q, coin_req_d;
  logic             coin_sel_q, coin_sel_d;
  logic             credit_clr_q, credit_clr_d;
  logic             short_q, short_d;
  logic             fault_q, fault_d;
  logic             refund_edge;
  logic             dec_dollar, dec_quarter;
  logic             ld_dollar, ld_quarter;

  assign refund_edge = refund & ~refund_prev_q;

  coin_stock u_dollar_stock (
    .clk     (clk),
    .rst_n   (rst_n),
    .dec_i   (dec_dollar),
    .load_i  (ld_dollar),
    .empty_o (dollar_empty)
  );

  coin_stock u_quarter_stock (
    .clk     (clk),
    .rst_n   (rst_n),
    .dec_i   (dec_quarter),
    .load_i  (ld_quarter),
    .empty_o (quarter_empty)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    residual_d   = residual_q;
    timer_d      = timer_q;
    coin_req_d   = coin_req_q;
    coin_sel_d   = coin_sel_q;
    credit_clr_d = 1'b0;
    short_d      = short_q;
    fault_d      = fault_q;
    dec_dollar   = 1'b0;
    dec_quarter  = 1'b0;
    ld_dollar    = 1'b0;
    ld_quarter   = 1'b0;

    case (state_q)
      IDLE: begin
        // A refund edge wins over a simultaneous refill request.
        if (refund_edge) begin
          remaining_d  = money_in;
          credit_clr_d = 1'b1;
          residual_d   = '0;
          short_d      = 1'b0;
          fault_d      = 1'b0;
          state_d      = SELECT;
        end else begin
          ld_dollar  = load_dollar;
          ld_quarter = load_quarter;
        end
      end

      SELECT: begin
        timer_d = '0;
        if ((remaining_q >= DOLLAR) && !dollar_empty) begin
          coin_sel_d = 1'b1;
          coin_req_d = 1'b1;
          state_d    = WAIT_ACK;
        end else if ((remaining_q >= QUARTER) && !quarter_empty) begin
          coin_sel_d = 1'b0;
          coin_req_d = 1'b1;
          state_d    = WAIT_ACK;
        end else begin
          state_d = FINISH;
        end
      end

      WAIT_ACK: begin
        if (coin_ack) begin
          coin_req_d = 1'b0;
          if (coin_sel_q) begin
            remaining_d = remaining_q - DOLLAR;
            dec_dollar  = 1'b1;
          end else begin
            remaining_d = remaining_q - QUARTER;
            dec_quarter = 1'b1;
          end
          state_d = WAIT_REL;
        end else if (timer_q == TMO_LAST) begin
          // Unpaid coin stays in remaining and is reported as residual.
          coin_req_d = 1'b0;
          fault_d    = 1'b1;
          state_d    = FINISH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      WAIT_REL: begin
        if (!coin_ack) begin
          state_d = SELECT;
        end
      end

      FINISH: begin
        residual_d = remaining_q;
        short_d    = (remaining_q != '0);
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      refund_prev_q <= 1'b0;
      remaining_q   <= '0;
      residual_q    <= '0;
      timer_q       <= '0;
      coin_req_q    <= 1'b0;
      coin_sel_q    <= 1'b0;
      credit_clr_q  <= 1'b0;
      short_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      refund_prev_q <= refund;
      remaining_q   <= remaining_d;
      residual_q    <= residual_d;
      timer_q       <= timer_d;
      coin_req_q    <= coin_req_d;
      coin_sel_q    <= coin_sel_d;
      credit_clr_q  <= credit_clr_d;
      short_q       <= short_d;
      fault_q       <= fault_d;
    end
  end

  assign credit_clr   = credit_clr_q;
  assign coin_req     = coin_req_q;
  assign coin_sel     = coin_sel_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FINISH);
  assign residual     = residual_q;
  assign short_change = short_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized and directed bench for change_dispenser with a hopper model
module tb_change_dispenser;

  logic        clk;
  logic        rst_n;
  logic        refund;
  logic [11:0] money_in;
  logic        load_dollar;
  logic        load_quarter;
  logic        coin_ack;
  logic        credit_clr;
  logic        coin_req;
  logic        coin_sel;
  logic        busy;
  logic        done;
  logic [11:0] residual;
  logic        short_change;
  logic        fault;
  logic        dollar_empty;
  logic        quarter_empty;

  change_dispenser dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .refund        (refund),
    .money_in      (money_in),
    .load_dollar   (load_dollar),
    .load_quarter  (load_quarter),
    .coin_ack      (coin_ack),
    .credit_clr    (credit_clr),
    .coin_req      (coin_req),
    .coin_sel      (coin_sel),
    .busy          (busy),
    .done          (done),
    .residual      (residual),
    .short_change  (short_change),
    .fault         (fault),
    .dollar_empty  (dollar_empty),
    .quarter_empty (quarter_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference stock levels, 15 = full.
  int md = 15;
  int mq = 15;

  int clr_cnt = 0;
  int done_cnt = 0;
  int req_hi_cnt = 0;
  int sel_glitch = 0;
  bit hopper_en = 1'b1;
  bit coins[$];

  // Hopper: ack 2 cycles after request, release 1 cycle after request drops.
  initial begin
    int  hold;
    bit  prev_req;
    bit  prev_sel;
    hold     = 0;
    prev_req = 1'b0;
    prev_sel = 1'b0;
    coin_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (credit_clr === 1'b1) clr_cnt++;
      if (done === 1'b1) done_cnt++;
      if (coin_req === 1'b1) req_hi_cnt++;
      if (coin_req === 1'b1 && prev_req && coin_sel !== prev_sel) sel_glitch++;
      prev_req = (coin_req === 1'b1);
      prev_sel = coin_sel;
      if (!rst_n) begin
        coin_ack = 1'b0;
        hold     = 0;
      end else if (!coin_ack) begin
        if (coin_req === 1'b1 && hopper_en) begin
          hold++;
          if (hold >= 2) begin
            coin_ack = 1'b1;
            coins.push_back(coin_sel);
            hold = 0;
          end
        end else begin
          hold = 0;
        end
      end else if (coin_req !== 1'b1) begin
        coin_ack = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_load();
    load_dollar  = 1'b1;
    load_quarter = 1'b1;
    tick();
    load_dollar  = 1'b0;
    load_quarter = 1'b0;
    tick();
    md = 15;
    mq = 15;
  endtask

  // Greedy payout computed from coin counts; with no hopper the first coin times out.
  task automatic run_refund(input string tag, input int money, input bit hop_ok,
                            input bit ld_same, input bit rebounce);
    int nd, nq, resid, lat, clr0, done0, req0;
    bit flt, seen, exp_req;
    logic [63:0] obs_pat, exp_pat;
    if (hop_ok) begin
      nd    = (money / 100 < md) ? money / 100 : md;
      nq    = ((money - 100 * nd) / 25 < mq) ? (money - 100 * nd) / 25 : mq;
      resid = money - 100 * nd - 25 * nq;
      flt   = 1'b0;
      exp_req = (nd + nq) > 0;
    end else begin
      nd    = 0;
      nq    = 0;
      resid = money;
      flt   = (money >= 100 && md > 0) || (money >= 25 && mq > 0);
      exp_req = flt;
    end
    md -= nd;
    mq -= nq;

    clr0  = clr_cnt;
    done0 = done_cnt;
    req0  = req_hi_cnt;
    coins.delete();
    hopper_en = hop_ok;
    money_in  = 12'(money);
    refund    = 1'b1;
    if (ld_same) begin
      load_dollar  = 1'b1;
      load_quarter = 1'b1;
    end
    lat  = -1;
    seen = 1'b0;
    for (int n = 1; n <= 600 && !seen; n++) begin
      tick();
      if (n == 1) begin
        refund       = 1'b0;
        load_dollar  = 1'b0;
        load_quarter = 1'b0;
      end
      if (rebounce && n == 3) refund = 1'b1;
      if (rebounce && n == 4) begin
        refund      = 1'b0;
        load_dollar = 1'b1;
      end
      if (rebounce && n == 5) load_dollar = 1'b0;
      if (lat < 0 && coin_req === 1'b1) lat = n;
      if (done_cnt > done0) seen = 1'b1;
    end
    check({tag, ".done_seen"}, 64'(seen), 64'd1);
    tick();
    check({tag, ".done_pulses"}, 64'(done_cnt - done0), 64'd1);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".credit_clr"}, 64'(clr_cnt - clr0), 64'd1);
    check({tag, ".residual"}, 64'(residual), 64'(resid));
    check({tag, ".short_change"}, 64'(short_change), 64'(resid != 0));
    check({tag, ".fault"}, 64'(fault), 64'(flt));
    check({tag, ".dollar_empty"}, 64'(dollar_empty), 64'(md == 0));
    check({tag, ".quarter_empty"}, 64'(quarter_empty), 64'(mq == 0));
    check({tag, ".coin_count"}, 64'(coins.size()), 64'(nd + nq));
    obs_pat = '0;
    foreach (coins[i]) obs_pat = (obs_pat << 1) | 64'(coins[i]);
    exp_pat = ((64'd1 << nd) - 64'd1) << nq;
    check({tag, ".coin_order"}, obs_pat, exp_pat);
    if (exp_req) check({tag, ".latency"}, 64'(lat), 64'd2);
    else check({tag, ".no_req"}, 64'(req_hi_cnt - req0), 64'd0);
    if (flt) check({tag, ".req_hold"}, 64'(req_hi_cnt - req0), 64'd255);
  endtask

  initial begin
    rst_n        = 1'b0;
    refund       = 1'b0;
    money_in     = '0;
    load_dollar  = 1'b0;
    load_quarter = 1'b0;
    tick();
    tick();
    check("rst.coin_req", 64'(coin_req), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.credit_clr", 64'(credit_clr), 64'd0);
    check("rst.residual", 64'(residual), 64'd0);
    check("rst.short_fault", 64'({short_change, fault}), 64'd0);
    check("rst.empties", 64'({dollar_empty, quarter_empty}), 64'd0);
    rst_n = 1'b1;
    tick();

    run_refund("t1_250", 250, 1'b1, 1'b0, 1'b0);
    run_refund("t2_130", 130, 1'b1, 1'b0, 1'b0);

    pulse_load();
    for (int i = 1; i <= 16; i++) begin
      run_refund($sformatf("t3_r%0d", i), 100, 1'b1, 1'b0, 1'b0);
      if (i == 15) check("t3.dollar_empty_15", 64'(dollar_empty), 64'd1);
    end

    pulse_load();
    run_refund("t4_timeout", 100, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a handshake.
    hopper_en = 1'b0;
    money_in  = 12'd100;
    refund    = 1'b1;
    tick();
    refund = 1'b0;
    tick();
    check("t5.req_before_rst", 64'(coin_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5.req_async", 64'(coin_req), 64'd0);
    check("t5.busy_async", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    md = 15;
    mq = 15;
    tick();
    check("t5.idle", 64'(busy), 64'd0);
    check("t5.empties", 64'({dollar_empty, quarter_empty}), 64'd0);
    run_refund("t5_full", 1500, 1'b1, 1'b0, 1'b0);

    pulse_load();
    run_refund("t6_rebounce", 200, 1'b1, 1'b0, 1'b1);
    run_refund("t6_zero", 0, 1'b1, 1'b0, 1'b0);
    run_refund("t6_priority", 125, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) pulse_load();
      run_refund($sformatf("rnd%0d", i), 5 * int'($urandom_range(0, 60)), 1'b1,
                 1'($urandom_range(0, 1)), 1'b0);
    end

    check("sel_stable", 64'(sel_glitch), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
